// File: rtl/decoder_scan_if.sv
// decoder_scan_if: select/enable inputs and registered decode outputs of decoder_scan
interface decoder_scan_if #(
  parameter int SEL_W = 3,
  parameter int OUTS  = 8
);
  logic             en;
  logic             mode;
  logic [SEL_W-1:0] x;
  logic [OUTS-1:0]  D;
  logic [SEL_W-1:0] idx;
  logic             oor;
  logic             wrap;
  modport master (output en, mode, x, input D, idx, oor, wrap);
  modport slave  (input en, mode, x, output D, idx, oor, wrap);
endinterface

// File: rtl/decoder_scan.sv
// decoder_scan: registered one-hot decoder with DIRECT select and auto-sequencing SCAN modes
module decoder_scan #(
  parameter int SEL_W   = 3,
  parameter int OUTS    = 8,
  parameter int DIV     = 4,
  parameter int ACT_LOW = 0
) (
  input logic           clk,
  input logic           rst,
  decoder_scan_if.slave bus
);
  localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [SEL_W:0]   OUTS_V = (SEL_W+1)'(OUTS);
  localparam logic [SEL_W-1:0] LAST   = SEL_W'(OUTS-1);
  localparam logic [PW-1:0]    PMAX   = PW'(DIV-1);
  localparam logic [OUTS-1:0]  ONE    = OUTS'(1);
  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;
  state_t state, state_n;
  logic [OUTS-1:0]  act, act_n;
  logic [SEL_W-1:0] idx, idx_n;
  logic [PW-1:0]    pre, pre_n;
  logic             oor, oor_n, wrap, wrap_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_n;
  always_comb state_n = !bus.en ? IDLE : bus.mode ? SCAN : DIRECT;
  // state holds the previous edge's mode, so state != SCAN marks scan entry
  always_comb begin
    act_n  = act;
    idx_n  = idx;
    pre_n  = '0;
    oor_n  = 1'b0;
    wrap_n = 1'b0;
    if (state_n == IDLE) begin
      act_n = '0;
    end else if (state_n == DIRECT) begin
      idx_n = bus.x;
      oor_n = !({1'b0, bus.x} < OUTS_V);
      act_n = oor_n ? '0 : ONE << bus.x;
    end else if (state != SCAN) begin
      idx_n = '0;
      act_n = ONE;
    end else if (pre == PMAX) begin
      wrap_n = (idx == LAST);
      idx_n  = wrap_n ? '0 : idx + SEL_W'(1);
      act_n  = ONE << idx_n;
    end else begin
      pre_n = pre + PW'(1);
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      act  <= '0;
      idx  <= '0;
      pre  <= '0;
      oor  <= 1'b0;
      wrap <= 1'b0;
    end else begin
      act  <= act_n;
      idx  <= idx_n;
      pre  <= pre_n;
      oor  <= oor_n;
      wrap <= wrap_n;
    end
  assign bus.D    = (ACT_LOW != 0) ? ~act : act;
  assign bus.idx  = idx;
  assign bus.oor  = oor;
  assign bus.wrap = wrap;
endmodule

// File: tb/tb_decoder_scan.sv
// tb_decoder_scan: directed scoreboard bench over default, OUTS=6 and DIV=1/ACT_LOW decoders
module tb_decoder_scan;
  logic clk = 1'b0;
  logic rst, en, mode;
  logic [2:0] x;
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic [7:0] d;
    logic [2:0] ix;
    logic       o;
    logic       w;
    string      tag;
  } exp_t;
  exp_t q[$];
  decoder_scan_if #(.SEL_W(3), .OUTS(8)) b0 ();
  decoder_scan_if #(.SEL_W(3), .OUTS(6)) b1 ();
  decoder_scan_if #(.SEL_W(3), .OUTS(8)) b2 ();
  assign b0.en = en; assign b0.mode = mode; assign b0.x = x;
  assign b1.en = en; assign b1.mode = mode; assign b1.x = x;
  assign b2.en = en; assign b2.mode = mode; assign b2.x = x;
  decoder_scan #(.SEL_W(3), .OUTS(8), .DIV(4), .ACT_LOW(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  decoder_scan #(.SEL_W(3), .OUTS(6), .DIV(4), .ACT_LOW(0)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  decoder_scan #(.SEL_W(3), .OUTS(8), .DIV(1), .ACT_LOW(1)) dut2 (.clk(clk), .rst(rst), .bus(b2));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] ex);
    checks++;
    assert (obs === ex) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, ex);
    end
  endtask
  task automatic cyc(input logic e, input logic m, input logic [2:0] xv,
                     input logic [7:0] d, input logic [2:0] ix, input logic o, input logic w,
                     input string tag);
    exp_t ex;
    q.push_back('{d, ix, o, w, tag});
    en = e; mode = m; x = xv;
    @(posedge clk);
    #1;
    ex = q.pop_front();
    chk({ex.tag, "_D"}, b0.D, ex.d);
    chk({ex.tag, "_idx"}, b0.idx, ex.ix);
    chk({ex.tag, "_oor"}, b0.oor, ex.o);
    chk({ex.tag, "_wrap"}, b0.wrap, ex.w);
  endtask
  task automatic scan_run(input int c0, input int c1);
    int i0, i1, i2;
    logic [7:0] dl;
    for (int c = c0; c <= c1; c++) begin
      i0 = (c / 4) % 8;
      cyc(1'b1, 1'b1, 3'd0, 8'(1) << i0, 3'(i0), 1'b0, c > 0 && c % 4 == 0 && i0 == 0, "scan");
      i1 = (c / 4) % 6;
      chk("scan6_idx", b1.idx, i1);
      chk("scan6_wrap", b1.wrap, c > 0 && c % 4 == 0 && i1 == 0);
      i2 = c % 8;
      dl = ~(8'(1) << i2);
      chk("scan_al_D", b2.D, dl);
      chk("scan_al_wrap", b2.wrap, c > 0 && i2 == 0);
    end
  endtask
  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0; x = 3'd5;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_D", b0.D, 8'h00);
    chk("rst_idx", b0.idx, 3'd0);
    chk("rst_oor", b0.oor, 1'b0);
    chk("rst_wrap", b0.wrap, 1'b0);
    chk("rst_al_D", b2.D, 8'hFF);
    rst = 1'b0;
    repeat (3) cyc(1'b0, 1'b0, 3'd5, 8'h00, 3'd0, 1'b0, 1'b0, "idle");
    for (int i = 0; i < 8; i++)
      cyc(1'b1, 1'b0, 3'(i), 8'(1) << i, 3'(i), 1'b0, 1'b0, "direct");
    cyc(1'b1, 1'b0, 3'd6, 8'h40, 3'd6, 1'b0, 1'b0, "direct6");
    chk("oor6_D", b1.D, 6'h00);
    chk("oor6_oor", b1.oor, 1'b1);
    cyc(1'b1, 1'b0, 3'd7, 8'h80, 3'd7, 1'b0, 1'b0, "direct7");
    chk("oor7_D", b1.D, 6'h00);
    chk("oor7_oor", b1.oor, 1'b1);
    chk("oor7_idx", b1.idx, 3'd7);
    cyc(1'b1, 1'b0, 3'd2, 8'h04, 3'd2, 1'b0, 1'b0, "direct2");
    chk("inr2_D", b1.D, 6'h04);
    chk("inr2_oor", b1.oor, 1'b0);
    scan_run(0, 36);
    cyc(1'b1, 1'b0, 3'd1, 8'h02, 3'd1, 1'b0, 1'b0, "leave");
    scan_run(0, 12);
    cyc(1'b1, 1'b0, 3'd6, 8'h40, 3'd6, 1'b0, 1'b0, "mid_direct");
    cyc(1'b1, 1'b1, 3'd6, 8'h01, 3'd0, 1'b0, 1'b0, "rescan");
    scan_run(1, 5);
    cyc(1'b0, 1'b1, 3'd0, 8'h00, 3'd1, 1'b0, 1'b0, "idle_hold");
    scan_run(0, 6);
    #3 rst = 1'b1;
    #1;
    chk("async_D", b0.D, 8'h00);
    chk("async_idx", b0.idx, 3'd0);
    chk("async_al_D", b2.D, 8'hFF);
    #2 rst = 1'b0;
    cyc(1'b1, 1'b1, 3'd0, 8'h01, 3'd0, 1'b0, 1'b0, "post_rst");
    chk("post_rst_al_D", b2.D, 8'hFE);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
